// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler: in-order instruction buffer that issues one or two instructions per cycle to decode.
// Optional statistics counters are enabled with `define SCHED_STATS_EN.
module dual_issue_scheduler #(
    parameter int DEPTH = 8,
    parameter int IW    = 32,
    parameter int PCW   = 32
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic [1:0]               i_in_valid,
    input  logic [IW-1:0]            i_in_instr0,
    input  logic [IW-1:0]            i_in_instr1,
    input  logic [PCW-1:0]           i_in_pc0,
    input  logic [PCW-1:0]           i_in_pc1,
    output logic                     o_in_ready,
    input  logic                     i_issue_stall,
    output logic                     o_out_valid0,
    output logic                     o_out_valid1,
    output logic [IW-1:0]            o_out_instr0,
    output logic [IW-1:0]            o_out_instr1,
    output logic [PCW-1:0]           o_out_pc0,
    output logic [PCW-1:0]           o_out_pc1,
    output logic [$clog2(DEPTH):0]   o_count
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]              o_dual_cnt,
    output logic [31:0]              o_single_cnt,
    output logic [31:0]              o_split_hazard_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);

    function automatic logic f_mem(input logic [IW-1:0] x);
        return x[31:26] == 6'h23 || x[31:26] == 6'h2b;
    endfunction

    function automatic logic f_ctrl(input logic [IW-1:0] x);
        return x[31:26] == 6'h04 || x[31:26] == 6'h05 || x[31:26] == 6'h02 || x[31:26] == 6'h03;
    endfunction

    // Destination register; 0 means the instruction writes nothing that can hazard.
    function automatic logic [4:0] f_dest(input logic [IW-1:0] x);
        return x[31:26] == 6'h00 ? x[15:11] :
               (x[31:26] == 6'h08 || x[31:26] == 6'h0d || x[31:26] == 6'h23) ? x[20:16] :
               x[31:26] == 6'h03 ? 5'd31 : 5'd0;
    endfunction

    function automatic logic f_uses_rs(input logic [IW-1:0] x);
        return !(x[31:26] == 6'h02 || x[31:26] == 6'h03);
    endfunction

    // Unknown opcodes conservatively read rt as well.
    function automatic logic f_uses_rt(input logic [IW-1:0] x);
        return f_uses_rs(x) && !(x[31:26] == 6'h08 || x[31:26] == 6'h0d || x[31:26] == 6'h23);
    endfunction

    logic [IW-1:0]  r_instr [DEPTH];
    logic [PCW-1:0] r_pc    [DEPTH];
    logic [AW-1:0]  r_head;
    logic [AW-1:0]  r_tail;
    logic [AW:0]    r_count;

    logic [AW-1:0]  w_head1;
    logic [AW-1:0]  w_tail1;
    logic [IW-1:0]  w_i0;
    logic [IW-1:0]  w_i1;
    logic [4:0]     w_d0;
    logic           w_raw;
    logic           w_waw;
    logic           w_pair_ok;
    logic           w_valid0;
    logic           w_valid1;
    logic           w_enq0;
    logic           w_enq1;
    logic [AW:0]    w_enq_n;
    logic [AW:0]    w_deq_n;

    assign w_head1   = r_head + AW'(1);
    assign w_tail1   = r_tail + AW'(1);
    assign w_i0      = r_instr[r_head];
    assign w_i1      = r_instr[w_head1];
    assign w_d0      = f_dest(w_i0);
    assign w_raw     = w_d0 != 5'd0 && ((f_uses_rs(w_i1) && w_i1[25:21] == w_d0) || (f_uses_rt(w_i1) && w_i1[20:16] == w_d0));
    assign w_waw     = w_d0 != 5'd0 && w_d0 == f_dest(w_i1);
    assign w_pair_ok = !(f_mem(w_i0) && f_mem(w_i1)) && !f_ctrl(w_i0) && !w_raw && !w_waw;
    assign w_valid0  = r_count != '0 && !i_issue_stall && !i_flush;
    assign w_valid1  = w_valid0 && r_count >= (AW+1)'(2) && w_pair_ok;
    assign w_enq0    = o_in_ready && i_in_valid[0];
    assign w_enq1    = w_enq0 && i_in_valid[1];
    assign w_enq_n   = (AW+1)'(w_enq0) + (AW+1)'(w_enq1);
    assign w_deq_n   = (AW+1)'(w_valid0) + (AW+1)'(w_valid1);

    assign o_in_ready   = r_count <= (AW+1)'(DEPTH - 2);
    assign o_count      = r_count;
    assign o_out_valid0 = w_valid0;
    assign o_out_valid1 = w_valid1;
    assign o_out_instr0 = w_valid0 ? w_i0 : '0;
    assign o_out_instr1 = w_valid1 ? w_i1 : '0;
    assign o_out_pc0    = w_valid0 ? r_pc[r_head] : '0;
    assign o_out_pc1    = w_valid1 ? r_pc[w_head1] : '0;

    // Pointer and occupancy update; flush empties the buffer and wins over enqueue/dequeue.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_deq_n);
            r_tail  <= r_tail + AW'(w_enq_n);
            r_count <= r_count + w_enq_n - w_deq_n;
        end
    end

    // Buffer storage; entries written during a flush are orphaned by the pointer reset.
    always_ff @(posedge i_clk) begin
        if (w_enq0) begin
            r_instr[r_tail] <= i_in_instr0;
            r_pc[r_tail]    <= i_in_pc0;
        end
        if (w_enq1) begin
            r_instr[w_tail1] <= i_in_instr1;
            r_pc[w_tail1]    <= i_in_pc1;
        end
    end

`ifdef SCHED_STATS_EN
    logic [31:0] r_dual_cnt;
    logic [31:0] r_single_cnt;
    logic [31:0] r_split_hazard_cnt;

    assign o_dual_cnt         = r_dual_cnt;
    assign o_single_cnt       = r_single_cnt;
    assign o_split_hazard_cnt = r_split_hazard_cnt;

    // Saturating issue statistics; survive flush, cleared only by reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dual_cnt         <= '0;
            r_single_cnt       <= '0;
            r_split_hazard_cnt <= '0;
        end else begin
            if (w_valid1 && ~&r_dual_cnt) r_dual_cnt <= r_dual_cnt + 32'd1;
            if (w_valid0 && !w_valid1 && ~&r_single_cnt) r_single_cnt <= r_single_cnt + 32'd1;
            if (w_valid0 && r_count >= (AW+1)'(2) && !w_pair_ok && ~&r_split_hazard_cnt)
                r_split_hazard_cnt <= r_split_hazard_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb_dual_issue_scheduler: directed stimulus checked against a queue-based model of the scheduler.
module tb_dual_issue_scheduler;
    localparam int DEPTH = 8;
    localparam logic [31:0] ADD  = 32'h00221820;
    localparam logic [31:0] ADDI = 32'h20A40001;
    localparam logic [31:0] SUB  = 32'h00642822;
    localparam logic [31:0] LW   = 32'h8CE60000;
    localparam logic [31:0] SW   = 32'hAD280004;
    localparam logic [31:0] BEQ  = 32'h10220003;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  iv = 2'b00;
    logic [31:0] ia = '0;
    logic [31:0] ib = '0;
    logic [31:0] pa = '0;
    logic [31:0] pb = '0;
    logic [31:0] pc = 32'h1000;
    logic        o_ready;
    logic        o_v0;
    logic        o_v1;
    logic [31:0] o_i0;
    logic [31:0] o_i1;
    logic [31:0] o_p0;
    logic [31:0] o_p1;
    logic [3:0]  o_count;

    int checks = 0;
    int errors = 0;
    logic [63:0] q[$];

    dual_issue_scheduler #(.DEPTH(DEPTH), .IW(32), .PCW(32)) dut (
        .i_clk(clk), .i_reset(rst), .i_flush(flush), .i_in_valid(iv),
        .i_in_instr0(ia), .i_in_instr1(ib), .i_in_pc0(pa), .i_in_pc1(pb),
        .o_in_ready(o_ready), .i_issue_stall(stall),
        .o_out_valid0(o_v0), .o_out_valid1(o_v1),
        .o_out_instr0(o_i0), .o_out_instr1(o_i1),
        .o_out_pc0(o_p0), .o_out_pc1(o_p1), .o_count(o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dest_of(input logic [31:0] x);
        case (int'(x[31:26]))
            0:         return int'(x[15:11]);
            8, 13, 35: return int'(x[20:16]);
            3:         return 31;
            default:   return 0;
        endcase
    endfunction

    function automatic bit reads(input logic [31:0] x, input int r);
        case (int'(x[31:26]))
            8, 13, 35: return int'(x[25:21]) == r;
            2, 3:      return 1'b0;
            default:   return int'(x[25:21]) == r || int'(x[20:16]) == r;
        endcase
    endfunction

    function automatic bit pair_ok(input logic [31:0] a, input logic [31:0] b);
        int op_a, op_b, d;
        op_a = int'(a[31:26]);
        op_b = int'(b[31:26]);
        d = dest_of(a);
        if ((op_a == 35 || op_a == 43) && (op_b == 35 || op_b == 43)) return 1'b0;
        if (op_a inside {2, 3, 4, 5}) return 1'b0;
        if (d != 0 && (reads(b, d) || dest_of(b) == d)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int issue_n();
        if (q.size() == 0 || stall || flush) return 0;
        if (q.size() >= 2 && pair_ok(q[0][31:0], q[1][31:0])) return 2;
        return 1;
    endfunction

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        int n;
        n = issue_n();
        chk("count", 32'(o_count), 32'(q.size()));
        chk("ready", 32'(o_ready), 32'(q.size() <= DEPTH - 2));
        chk("valid0", 32'(o_v0), 32'(n >= 1));
        chk("valid1", 32'(o_v1), 32'(n == 2));
        if (n >= 1) begin
            chk("instr0", o_i0, q[0][31:0]);
            chk("pc0", o_p0, q[0][63:32]);
        end
        if (n == 2) begin
            chk("instr1", o_i1, q[1][31:0]);
            chk("pc1", o_p1, q[1][63:32]);
        end
    end

    // Model state: a queue of {pc, instr} entries, oldest first.
    always @(posedge clk or posedge rst) begin
        int n;
        bit rdy;
        if (rst || flush) begin
            q.delete();
        end else begin
            n = issue_n();
            rdy = q.size() <= DEPTH - 2;
            repeat (n) void'(q.pop_front());
            if (rdy && iv[0]) begin
                q.push_back({pa, ia});
                if (iv[1]) q.push_back({pb, ib});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b, input logic fl);
        iv = v;
        ia = a;
        ib = b;
        pa = pc;
        pb = pc + 32'd4;
        pc = pc + 32'd8;
        flush = fl;
        tick();
        iv = 2'b00;
        flush = 1'b0;
    endtask

    function automatic logic [31:0] mk(input int n);
        logic [31:0] k;
        k = 32'((n % 30) + 1);
        return 32'h20000000 | (k << 16) | 32'(n & 16'hffff);
    endfunction

    initial begin
        int n;
        int k;
        #1 rst = 1'b1;
        #1;
        chk("rst_count", 32'(o_count), 0);
        chk("rst_ready", 32'(o_ready), 1);
        chk("rst_v0", 32'(o_v0), 0);
        chk("rst_instr0", o_i0, 0);
        #20 rst = 1'b0;
        tick();

        cyc(2'b11, ADD, ADDI, 1'b0);
        chk("dual_v0", 32'(o_v0), 1);
        chk("dual_v1", 32'(o_v1), 1);
        chk("dual_i0", o_i0, ADD);
        chk("dual_i1", o_i1, ADDI);
        chk("dual_pc1", o_p1, 32'h1004);
        chk("dual_count", 32'(o_count), 2);
        tick();
        chk("dual_drained", 32'(o_count), 0);

        cyc(2'b11, ADD, SUB, 1'b0);
        chk("raw_v1", 32'(o_v1), 0);
        chk("raw_i0", o_i0, ADD);
        tick();
        chk("raw_second", o_i0, SUB);
        tick();

        cyc(2'b11, LW, SW, 1'b0);
        chk("mem_v1", 32'(o_v1), 0);
        tick();
        chk("mem_second", o_i0, SW);
        tick();
        cyc(2'b11, BEQ, ADD, 1'b0);
        chk("ctl_v1", 32'(o_v1), 0);
        chk("ctl_i0", o_i0, BEQ);
        tick();
        chk("ctl_second", o_i0, ADD);
        tick();
        cyc(2'b11, ADDI, BEQ, 1'b0);
        chk("ctl_slot1", 32'(o_v1), 1);
        tick();

        cyc(2'b10, ADD, ADD, 1'b0);
        chk("v10_count", 32'(o_count), 0);
        cyc(2'b01, ADDI, ADD, 1'b0);
        tick();

        n = 0;
        for (int f = 0; f < 3; f++) begin
            stall = 1'b1;
            for (int i = 0; i < 6; i++) begin
                if (o_ready) begin
                    cyc(2'b11, mk(n), mk(n + 1), 1'b0);
                    n += 2;
                end
            end
            cyc(2'b11, ADD, ADD, 1'b0);
            chk("full_count", 32'(o_count), DEPTH);
            chk("full_ready", 32'(o_ready), 0);
            chk("full_v0", 32'(o_v0), 0);
            stall = 1'b0;
            #1;
            chk("drain_v1", 32'(o_v1), 1);
            k = 0;
            while (o_count != 0 && k < 20) begin
                tick();
                k++;
            end
            chk("drain_bound", 32'(k < 20), 1);
        end

        stall = 1'b1;
        cyc(2'b11, ADD, ADDI, 1'b0);
        cyc(2'b11, SUB, LW, 1'b0);
        cyc(2'b01, SW, ADD, 1'b0);
        chk("pre_flush_count", 32'(o_count), 5);
        stall = 1'b0;
        iv = 2'b11;
        ia = ADD;
        ib = ADDI;
        flush = 1'b1;
        #1;
        chk("flush_v0", 32'(o_v0), 0);
        tick();
        iv = 2'b00;
        flush = 1'b0;
        chk("flush_count", 32'(o_count), 0);
        chk("flush_ready", 32'(o_ready), 1);
        chk("flush_v0_after", 32'(o_v0), 0);

        stall = 1'b1;
        cyc(2'b11, ADD, ADDI, 1'b0);
        stall = 1'b0;
        #1;
        chk("pre_rst_v0", 32'(o_v0), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(o_count), 0);
        chk("async_rst_v0", 32'(o_v0), 0);
        #10 rst = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- Instruction buffer and pairing scheduler between fetch and the dual control-unit decode stage of the superscalar core.
- Accepts up to two in-order instructions per cycle from fetch and holds them in a circular buffer.
- Each cycle, issues the oldest one or two instructions to decode slots 0/1, subject to structural and intra-pair dependency rules.
- Handles backend stall and pipeline flush.

Parameters:
- DEPTH, 8, buffer entries; power of 2, minimum 4.
- IW, 32, instruction width.
- PCW, 32, PC width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  discard all buffered instructions (branch/jump redirect).
- in_valid  in  2  bit0 = instr0 valid, bit1 = instr1 valid; bit1 ignored unless bit0 is set.
- in_instr0, in_instr1  in  IW  fetched instructions; instr0 is older.
- in_pc0, in_pc1  in  PCW  their PCs.
- in_ready  out  1  at least 2 free entries.
- issue_stall  in  1  backend cannot accept; no dequeue this cycle.
- out_valid0, out_valid1  out  1  slot 0/1 issuing this cycle.
- out_instr0, out_instr1  out  IW  issued instructions.
- out_pc0, out_pc1  out  PCW  issued PCs.
- count  out  log2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async):
  - head, tail and count = 0.
  - All out_valid = 0; out_instr/out_pc = 0.
  - in_ready = 1.
- Enqueue at a rising edge when in_ready & in_valid[0]: 1 or 2 entries written at tail in order. in_valid = 2'b10 is treated as no enqueue.
- in_ready = (DEPTH − count) ≥ 2; combinational from count.
- Issue candidates are the entries at head and head+1; out_* are combinational from buffer state.
  - Minimum latency: an instruction enqueued at edge N appears on out_* in the cycle after edge N.
- out_valid0 = count ≥ 1 & ~issue_stall & ~flush.
- out_valid1 = out_valid0 & count ≥ 2 & pair_ok.
- pair_ok is false if any of the following holds:
  - Both instructions are memory ops (opcode 0x23 lw, 0x2b sw): single memory port.
  - Slot0 is control (0x04 beq, 0x05 bne, 0x02 j, 0x03 jal): control instructions always issue alone or in slot1.
  - Both instructions are control.
  - RAW: dest(slot0) ≠ 0 and dest(slot0) matches a source of slot1.
  - WAW: dest(slot0) ≠ 0 and dest(slot0) == dest(slot1).
- Dest by opcode:
  - R-type (0x00): rd.
  - 0x08 addi, 0x0d ori, 0x23 lw: rt.
  - 0x03 jal: 31.
  - All others: none.
- Sources by opcode:
  - R-type, sw, beq, bne: rs and rt.
  - addi, ori, lw: rs.
  - j, jal: none.
  - Unknown opcodes: rs and rt (conservative), no dest, non-memory, non-control.
- Dequeue at the edge: head advances by out_valid0 + out_valid1; count is updated by enqueued − dequeued in the same edge.
- Simultaneous enqueue and dequeue is legal. Pointers wrap modulo DEPTH.
- Full: in_ready = 0 when 1 or 0 entries are free; fetch data is dropped, and fetch must hold it.
- Empty: both out_valid = 0.
- flush:
  - At the edge, head = tail = count = 0.
  - Same-cycle fetch input is dropped.
  - No issue in the flush cycle.
  - flush has priority over enqueue and dequeue.
- Reset asserted mid-operation clears immediately, without waiting for a clock edge.

Optional Feature:
- Macro: SCHED_STATS_EN.
- Defined: adds outputs dual_cnt[31:0], single_cnt[31:0] and split_hazard_cnt[31:0].
  - Cleared by reset. Not cleared by flush. Saturate at 0xFFFFFFFF.
  - dual_cnt increments on cycles with both slots valid.
  - single_cnt increments on cycles with only slot0 valid.
  - split_hazard_cnt increments when count ≥ 2, out_valid0 = 1 and pair_ok is false.
- Undefined: the ports and counters are absent; scheduling behaviour is identical.

Test Plan:
- Enqueue 0x00221820 (add $3,$1,$2) + 0x20A40001 (addi $4,$5,1) → next cycle out_valid0 = out_valid1 = 1, instructions in order, count 2 → 0.
- Enqueue 0x00221820 + 0x00642822 (sub $5,$3,$4) → cycle 1: slot0 only (RAW on $3); cycle 2: sub in slot0. With SCHED_STATS_EN, split_hazard_cnt = 1.
- Enqueue 0x8CE60000 (lw $6,0($7)) + 0xAD280004 (sw $8,4($9)) → issued in separate cycles (memory port). Enqueue 0x10220003 (beq) + 0x00221820 → beq issues alone.
- Hold issue_stall = 1 and enqueue pairs until in_ready = 0 → count = DEPTH−1 or DEPTH, no out_valid. Release the stall → dual issue drains the buffer in order, with pointer wrap verified across 3 fills.
- Buffer holding 5 entries, assert flush together with in_valid = 2'b11 → next cycle count = 0, no issue, in_ready = 1.
- Assert reset asynchronously between clock edges with the buffer non-empty → count = 0 and out_valid = 0 before the next edge.
